everloop_serializer: RTL and testbench
======================================

# everloop_serializer

Downstream consumer of the everloop frame RAM: continuously walks the RAM's read port in ascending byte order and converts every byte into a WS2812/SK6812 single-wire NRZ bitstream on the LED control pin. It is a free-running frame engine: stream all bytes, hold the line low for the latch gap, repeat. It has no bus interface. Host updates land in RAM asynchronously and appear on the next frame.

## Interface
- `N_LEDS`, 35: number of LEDs on the ring.
- `BYTES_PER_LED`, 4: bytes per LED. Emitted in RAM order; colour order is the RAM layout's concern.
- `ADR_WIDTH`, 11: RAM address width.
- `T_BIT`, 63: clock cycles per bit period (1.25 µs at 50 MHz).
- `T0H`, 20: high cycles for a 0 bit.
- `T1H`, 40: high cycles for a 1 bit.
- `T_LATCH`, 15000: low cycles between frames (300 µs at 50 MHz).
- `clk` in 1: single clock for all logic. RAM port B uses the same clock.
- `rst` in 1: reset, asynchronous and active-high.
- `enable` in 1: when low, frames are not started. A frame in progress completes.
- `address` out ADR_WIDTH: RAM port B read address.
- `data_rgb` in 8: RAM port B read data. Registered by the RAM, so valid 1 cycle after `address`.
- `everloop_d` out 1: NRZ LED data line.
- `frame_done` out 1: single-cycle pulse when the last bit of a frame completes.

## Operation
- `NBYTES = N_LEDS*BYTES_PER_LED`. Byte index `byte_cnt` runs 0..NBYTES-1, and `address = byte_cnt`, zero-extended.
- FSM states: LATCH, FETCH, SHIFT.
- **LATCH:**
  - Line is low. `latch_cnt` counts T_LATCH cycles.
  - At terminal count: go to FETCH if `enable`=1. Otherwise stay in LATCH with the counter saturated.
- **FETCH:**
  - `byte_cnt`=0 and `address`=0.
  - Wait 2 cycles (address setup + RAM latency).
  - Load `shreg`←`data_rgb`, set `bit_cnt`=7, go to SHIFT.
- **SHIFT:**
  - `phase_cnt` runs 0..T_BIT-1.
  - `everloop_d` = 1 while `phase_cnt` < (`shreg[7]` ? T1H : T0H), else 0.
  - At `phase_cnt`=T_BIT-1 with `bit_cnt`>0: shift `shreg` left, decrement `bit_cnt`.
  - Prefetch: at the first cycle of bit 7 of a byte, `address` advances to `byte_cnt+1`.
  - At the end of bit 0, `shreg`←`data_rgb` (the next byte, already valid). Inter-byte bitstream is gapless.
  - At the end of bit 0 of byte NBYTES-1: pulse `frame_done`, clear counters, go to LATCH.
  - After the last byte, `address` is not advanced beyond NBYTES-1.
- MSB of each byte is sent first.
- A bit's value is sampled once at `phase_cnt`=0 and held for the whole bit period.
- A RAM write during a frame:
  - If it lands before the byte's prefetch, it is visible in this frame.
  - Otherwise it appears next frame. No tearing protection is provided.

## Timing
- Reset values:
  - State LATCH, all counters 0.
  - `everloop_d`=0, `address`=0, `frame_done`=0.
- First rising edge of `everloop_d` after reset deassert: T_LATCH + 2 cycles, given `enable`=1.
- Frame period: T_LATCH + 2 + 8·NBYTES·T_BIT cycles. Default 15000 + 2 + 70560.
- `frame_done` is asserted for exactly 1 cycle, coincident with the first LATCH cycle.
- `rst` mid-frame: the line drops to 0 immediately (asynchronous). A full latch gap precedes the next frame.
- Parameter constraints (elaboration-time check):
  - 0 < T0H < T1H < T_BIT.
  - T_BIT ≥ 4.
  - NBYTES ≤ 2^ADR_WIDTH.
- Counter widths use `$clog2` of their terminal values.

## Structure
- Shared package `everloop_pkg`:
  - FSM state enum (LATCH/FETCH/SHIFT).
  - Default timing constants for 50 MHz.
  - `EVERLOOP_N_LEDS` and `EVERLOOP_BYTES_PER_LED`, shared with the Wishbone wrapper's RAM sizing.
- One natural sub-module: `everloop_bit_timer`.
  - Owns `phase_cnt`, the high/low compare and the end-of-bit strobe.
  - Inputs: bit value, start.
- The FSM, byte/bit counters and shift register stay in the top module.

## Test plan
- **Reset/latch:** reset with `enable`=1 and T_LATCH=100 → `everloop_d` stays 0 for 102 cycles after deassert, then rises; `address`=0 during FETCH.
- **Bit encoding:** N_LEDS=1, BYTES_PER_LED=1, RAM[0]=8'hA5, T_BIT=10, T0H=3, T1H=7 → high widths 7,3,7,3,3,7,3,7. Each bit period is exactly 10 cycles.
- **Gapless bytes and prefetch:** NBYTES=3, RAM={8'hFF,8'h00,8'h81} → 24 contiguous periods with no extra cycles at byte boundaries; `address` steps 0→1→2 at bit-7 starts and holds at 2.
- **Frame loop:** 2 consecutive frames → `frame_done` pulses once per frame; spacing equals the frame-period formula.
- **Enable gating:** deassert `enable` mid-frame → the current frame completes, then the line stays low indefinitely. Reassert → FETCH on the next cycle (counter already saturated).
- **Async reset mid-bit:** assert `rst` while `everloop_d`=1 → output 0 in the same cycle without waiting for a clock edge; the full latch gap is observed after release.

Source files
------------

// File: rtl/everloop_pkg.sv
// everloop_pkg: types and defaults shared by the everloop serializer
// and the Wishbone wrapper (ring size drives the frame RAM sizing).
package everloop_pkg;

  typedef enum logic [1:0] {
    LATCH,
    FETCH,
    SHIFT
  } state_t;

  localparam int EVERLOOP_N_LEDS        = 35;
  localparam int EVERLOOP_BYTES_PER_LED = 4;

  // 50 MHz timing
  localparam int EVERLOOP_T_BIT   = 63;
  localparam int EVERLOOP_T0H     = 20;
  localparam int EVERLOOP_T1H     = 40;
  localparam int EVERLOOP_T_LATCH = 15000;

  // counter width able to hold 0..n-1, never zero
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/everloop_bit_timer.sv
// everloop_bit_timer: one NRZ bit period with registered line level.
// Ports: clk, rst, start (begin a bit next cycle), bit_val, level, bit_end.
module everloop_bit_timer
  import everloop_pkg::*;
#(
  parameter int T_BIT = EVERLOOP_T_BIT,
  parameter int T0H   = EVERLOOP_T0H,
  parameter int T1H   = EVERLOOP_T1H
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic level,
  output logic bit_end
);

  localparam int PW = cnt_w(T_BIT);
  localparam logic [PW-1:0] LAST = PW'(T_BIT - 1);
  localparam logic [PW-1:0] HI1  = PW'(T1H);
  localparam logic [PW-1:0] HI0  = PW'(T0H);

  logic [PW-1:0] phase_cnt;
  logic [PW-1:0] phase_nxt;
  logic          active;

  assign phase_nxt = phase_cnt + PW'(1);
  assign bit_end   = active && (phase_cnt == LAST);

  // bit_val is the shift register MSB, which is stable for the
  // whole period, so it acts as the value sampled at phase 0.
  // Phase 0 is always high because T0H > 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
      active    <= 1'b0;
      level     <= 1'b0;
    end else if (start) begin
      phase_cnt <= '0;
      active    <= 1'b1;
      level     <= 1'b1;
    end else if (bit_end) begin
      phase_cnt <= '0;
      active    <= 1'b0;
      level     <= 1'b0;
    end else if (active) begin
      phase_cnt <= phase_nxt;
      level     <= phase_nxt < (bit_val ? HI1 : HI0);
    end
  end

endmodule

// File: rtl/everloop_serializer.sv
// everloop_serializer: streams the frame RAM as a WS2812 NRZ bitstream.
// Ports: clk, rst, enable, address/data_rgb (RAM port B), everloop_d, frame_done.
module everloop_serializer
  import everloop_pkg::*;
#(
  parameter int N_LEDS        = EVERLOOP_N_LEDS,
  parameter int BYTES_PER_LED = EVERLOOP_BYTES_PER_LED,
  parameter int ADR_WIDTH     = 11,
  parameter int T_BIT         = EVERLOOP_T_BIT,
  parameter int T0H           = EVERLOOP_T0H,
  parameter int T1H           = EVERLOOP_T1H,
  parameter int T_LATCH       = EVERLOOP_T_LATCH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [ADR_WIDTH-1:0] address,
  input  logic [7:0]           data_rgb,
  output logic                 everloop_d,
  output logic                 frame_done
);

  localparam int NBYTES = N_LEDS * BYTES_PER_LED;
  localparam int BW     = cnt_w(NBYTES);
  localparam int LW     = cnt_w(T_LATCH);

  localparam logic [BW-1:0]        LAST_BYTE  = BW'(NBYTES - 1);
  localparam logic [LW-1:0]        LAST_LATCH = LW'(T_LATCH - 1);
  localparam logic [ADR_WIDTH-1:0] LAST_ADR   = ADR_WIDTH'(NBYTES - 1);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_high
    $error("everloop: need 0 < T0H < T1H < T_BIT");
  end
  if (T_BIT < 4) begin : g_bad_bit
    $error("everloop: T_BIT must be at least 4");
  end
  if (NBYTES > (1 << ADR_WIDTH)) begin : g_bad_adr
    $error("everloop: frame does not fit the address space");
  end

  state_t         state;
  logic [LW-1:0]  latch_cnt;
  logic           fetch_cnt;
  logic [BW-1:0]  byte_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;

  logic bit_end;
  logic byte_end;
  logic frame_end;
  logic start;

  // prefetch target: the byte after b, held at the last byte
  function automatic logic [ADR_WIDTH-1:0] next_adr(
    input logic [BW-1:0] b
  );
    if (b == LAST_BYTE) return LAST_ADR;
    return ADR_WIDTH'(b) + ADR_WIDTH'(1);
  endfunction

  assign byte_end  = (state == SHIFT) && bit_end && (bit_cnt == 3'd0);
  assign frame_end = byte_end && (byte_cnt == LAST_BYTE);

  // the next bit starts on the same edge the previous one ends
  assign start = ((state == FETCH) && fetch_cnt) ||
                 ((state == SHIFT) && bit_end && !frame_end);

  everloop_bit_timer #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bit_val (shreg[7]),
    .level   (everloop_d),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LATCH;
      latch_cnt  <= '0;
      fetch_cnt  <= 1'b0;
      byte_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      address    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        LATCH: begin
          // saturate at terminal count until enabled
          if (latch_cnt == LAST_LATCH) begin
            if (enable) begin
              state     <= FETCH;
              latch_cnt <= '0;
            end
          end else begin
            latch_cnt <= latch_cnt + LW'(1);
          end
        end
        FETCH: begin
          // address 0 is already presented; second cycle has data
          fetch_cnt <= ~fetch_cnt;
          if (fetch_cnt) begin
            state   <= SHIFT;
            shreg   <= data_rgb;
            bit_cnt <= 3'd7;
            address <= next_adr(byte_cnt);
          end
        end
        SHIFT: begin
          if (bit_end) begin
            if (bit_cnt != 3'd0) begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - 3'd1;
            end else if (frame_end) begin
              state      <= LATCH;
              frame_done <= 1'b1;
              byte_cnt   <= '0;
              address    <= '0;
            end else begin
              // prefetched byte has been valid since bit 7 began
              shreg    <= data_rgb;
              bit_cnt  <= 3'd7;
              byte_cnt <= byte_cnt + BW'(1);
              address  <= next_adr(byte_cnt + BW'(1));
            end
          end
        end
        default: state <= LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_everloop_serializer.sv
// tb_everloop_serializer: scoreboard bench for the everloop serializer.
// Small timing (T_BIT=10, T0H=3, T1H=7, T_LATCH=100) and a 3-byte frame.
module tb_everloop_serializer;

  localparam int NB      = 3;
  localparam int TB_BIT  = 10;
  localparam int TB_LAT  = 100;
  localparam int FRAME   = TB_LAT + 2 + 8 * NB * TB_BIT;

  typedef struct {
    int hi;
    int period;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] address;
  logic [7:0] data_rgb;
  logic       everloop_d;
  logic       frame_done;

  logic [7:0] ram [0:15];
  exp_t        q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit ignore   = 1'b0;

  everloop_serializer #(
    .N_LEDS        (1),
    .BYTES_PER_LED (NB),
    .ADR_WIDTH     (4),
    .T_BIT         (TB_BIT),
    .T0H           (3),
    .T1H           (7),
    .T_LATCH       (TB_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .address    (address),
    .data_rgb   (data_rgb),
    .everloop_d (everloop_d),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port B: registered read
  always @(posedge clk) data_rgb <= ram[address];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic load_frame(input logic [7:0] b0, b1, b2);
    logic [7:0] b [3];
    b[0] = b0;
    b[1] = b1;
    b[2] = b2;
    for (int k = 0; k < 16; k++) ram[k] = 8'h00;
    for (int k = 0; k < NB; k++) begin
      ram[k] = b[k];
      for (int i = 7; i >= 0; i--) begin
        exp_t e;
        e.hi     = b[k][i] ? 7 : 3;
        e.period = (k == NB - 1 && i == 0) ? 0 : TB_BIT;
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_rise(output int n, input int limit);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!everloop_d && n < limit);
  endtask

  task automatic wait_done(output int n, input int limit);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < limit);
  endtask

  // monitor: measures each bit and compares against the scoreboard
  int cyc        = 0;
  int rise_cyc   = 0;
  int prev_per   = 0;
  int bit_idx    = 0;
  bit have_prev  = 1'b0;
  bit d_prev     = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ignore) begin
      have_prev = 1'b0;
      bit_idx   = 0;
    end else begin
      if (everloop_d && !d_prev) begin
        if (have_prev && prev_per != 0)
          check("bit_period", cyc - rise_cyc, prev_per);
        if (bit_idx % 8 == 0)
          check("prefetch_addr", int'(address),
                (bit_idx / 8 + 1 < NB) ? bit_idx / 8 + 1 : NB - 1);
        bit_idx++;
        rise_cyc  = cyc;
        have_prev = 1'b1;
      end
      if (!everloop_d && d_prev) begin
        if (q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("high_width", cyc - rise_cyc, e.hi);
          prev_per = e.period;
        end
      end
      if (frame_done) bit_idx = 0;
    end
    d_prev = everloop_d;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    rst    = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 16; k++) ram[k] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_d", int'(everloop_d), 0);
    check("rst_addr", int'(address), 0);
    check("rst_done", int'(frame_done), 0);

    // frame 1: first rise T_LATCH+2 cycles after release
    load_frame(8'hA5, 8'h00, 8'h81);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == TB_LAT + 1) check("fetch_addr", int'(address), 0);
    end while (!everloop_d && n < 1000);
    check("first_rise", n, TB_LAT + 2);
    wait_done(n, 1000);
    check("frame1_len", n, 8 * NB * TB_BIT);
    @(negedge clk);
    check("done_width", int'(frame_done), 0);
    check("latch_addr", int'(address), 0);

    // frame 2: new contents appear next frame
    load_frame(8'hFF, 8'h00, 8'h81);
    wait_done(n, 2000);
    check("frame_period", n + 1, FRAME);

    // frame 3: drop enable mid-frame, frame still completes
    load_frame(8'hA5, 8'h00, 8'h81);
    repeat (150) @(negedge clk);
    enable = 1'b0;
    wait_done(n, 1000);
    check("gated_done", int'(frame_done), 1);
    hi = 0;
    repeat (400) begin
      @(negedge clk);
      if (everloop_d) hi++;
    end
    check("gated_idle", hi, 0);

    // reenable: counter saturated, FETCH next cycle
    load_frame(8'h3C, 8'h00, 8'h81);
    enable = 1'b1;
    wait_rise(n, 100);
    check("reenable_rise", n, 3);

    // async reset while the line is high
    #2;
    ignore = 1'b1;
    rst    = 1'b1;
    #1;
    check("async_rst_d", int'(everloop_d), 0);
    check("async_rst_addr", int'(address), 0);
    q.delete();
    repeat (3) @(negedge clk);
    load_frame(8'h81, 8'hFF, 8'h5A);
    rst    = 1'b0;
    ignore = 1'b0;
    wait_rise(n, 1000);
    check("post_rst_rise", n, TB_LAT + 2);
    wait_done(n, 1000);
    check("post_rst_len", n, 8 * NB * TB_BIT);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
